// File: rtl/sequencer_core.sv
`default_nettype none
// ============================================================================
// Module   : sequencer_core
// Brief    : Microcoded output sequencer running a constant program ROM with
//            jump/call/return/counted loops over an internal LIFO stack.
//            Optional SEQ_STACK_ERR_EN adds a sticky stack_err output.
// Revision : 1.0 - initial release
// ============================================================================

`define SEQ_STOP   3'd0
`define SEQ_OUT    3'd1
`define SEQ_JMP    3'd2
`define SEQ_CALL   3'd3
`define SEQ_RET    3'd4
`define SEQ_PUSHI  3'd5
`define SEQ_DECJNZ 3'd6

module sequencer_core #(
  parameter int OCW  = 12,
  parameter int DDW  = 4,
  parameter int PLEN = 31,
  parameter int STD  = 256,
  parameter logic [PLEN*OCW-1:0] PROGRAM = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OCW-DDW-4:0]     addr,
  input  logic                   jump,
  output logic [DDW-1:0]         data_o,
  output logic [OCW-DDW-4:0]     pc,
  output logic                   stop
`ifdef SEQ_STACK_ERR_EN
  ,output logic                  stack_err
`endif
);

  localparam int AW   = OCW - 3 - DDW;
  localparam int SPW  = $clog2(STD + 1);
  localparam int IW   = (STD > 1) ? $clog2(STD) : 1;
  localparam int ROMD = 2 ** AW;

  localparam logic [AW-1:0]  c_one    = AW'(1);
  localparam logic [AW-1:0]  c_last   = AW'(PLEN - 1);
  localparam logic [SPW-1:0] c_sp_one = SPW'(1);
  localparam logic [SPW-1:0] c_std    = SPW'(STD);

  logic [AW-1:0]  r_pc;
  logic [AW-1:0]  r_cnt;
  logic [SPW-1:0] r_sp;
  logic [DDW-1:0] r_data;
  logic [AW-1:0]  r_stack [STD];

  logic [OCW-1:0] w_rom [ROMD];
  logic [OCW-1:0] w_instr;
  logic [2:0]     w_cmd;
  logic [AW-1:0]  w_n;
  logic [AW-1:0]  w_n_eff;
  logic [DDW-1:0] w_d;
  logic [AW-1:0]  w_pc_inc;
  logic [AW-1:0]  w_top;
  logic [IW-1:0]  w_top_idx;
  logic [IW-1:0]  w_push_idx;
  logic           w_empty;
  logic           w_full;
  logic           w_last;
  logic [AW-1:0]  w_pc_nxt;
  logic [AW-1:0]  w_cnt_nxt;
  logic           w_push;
  logic [AW-1:0]  w_push_val;
  logic           w_pop;
  logic           w_dec;

  // Words past the end of the program read as STOP, which also covers pc >= PLEN.
  for (genvar i = 0; i < ROMD; i++) begin : g_rom
    if (i < PLEN) begin : g_word
      assign w_rom[i] = PROGRAM[(PLEN-1-i)*OCW +: OCW];
    end else begin : g_pad
      assign w_rom[i] = '0;
    end
  end

  assign w_instr    = w_rom[r_pc];
  assign w_cmd      = w_instr[OCW-1 -: 3];
  assign w_n        = w_instr[DDW +: AW];
  assign w_d        = w_instr[DDW-1:0];
  assign w_n_eff    = (w_n == '0) ? c_one : w_n;
  assign w_last     = (r_cnt == (w_n_eff - c_one));
  assign w_pc_inc   = (r_pc == c_last) ? '0 : (r_pc + c_one);
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == c_std);
  assign w_top_idx  = IW'(r_sp - c_sp_one);
  assign w_push_idx = IW'(r_sp);
  assign w_top      = w_empty ? '0 : r_stack[w_top_idx];

  always_comb begin
    w_pc_nxt   = r_pc;
    w_cnt_nxt  = r_cnt;
    w_push     = 1'b0;
    w_push_val = '0;
    w_pop      = 1'b0;
    w_dec      = 1'b0;
    case (w_cmd)
      `SEQ_OUT: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          w_pc_nxt  = w_pc_inc;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      `SEQ_RET: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          w_pop     = !w_empty;
          w_pc_nxt  = w_empty ? w_pc_inc : w_top;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      `SEQ_JMP: begin
        w_pc_nxt = w_n;
      end
      `SEQ_CALL: begin
        w_push     = 1'b1;
        w_push_val = w_pc_inc;
        w_pc_nxt   = w_n;
      end
      `SEQ_PUSHI: begin
        w_push     = 1'b1;
        w_push_val = w_n;
        w_pc_nxt   = w_pc_inc;
      end
      `SEQ_DECJNZ: begin
        if (w_empty || (w_top <= c_one)) begin
          w_pop    = !w_empty;
          w_pc_nxt = w_pc_inc;
        end else begin
          w_dec    = 1'b1;
          w_pc_nxt = w_n;
        end
      end
      default: begin
        w_pc_nxt = r_pc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_cnt  <= '0;
      r_sp   <= '0;
      r_data <= '0;
    end else if (jump) begin
      r_pc  <= addr;
      r_cnt <= '0;
      r_sp  <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_cnt  <= w_cnt_nxt;
      r_data <= w_d;
      if (w_push && !w_full) begin
        r_sp <= r_sp + c_sp_one;
      end else if (w_pop) begin
        r_sp <= r_sp - c_sp_one;
      end
    end
  end

  // Stack contents need no reset; only entries below r_sp are ever read.
  always_ff @(posedge clk) begin
    if (!rst && !jump) begin
      if (w_push && !w_full) begin
        r_stack[w_push_idx] <= w_push_val;
      end else if (w_dec) begin
        r_stack[w_top_idx] <= w_top - c_one;
      end
    end
  end

`ifdef SEQ_STACK_ERR_EN
  logic w_under;
  logic r_err;

  assign w_under = ((w_cmd == `SEQ_RET) && w_last && w_empty) ||
                   ((w_cmd == `SEQ_DECJNZ) && w_empty);

  always_ff @(posedge clk) begin
    if (rst || jump) begin
      r_err <= 1'b0;
    end else if ((w_push && w_full) || w_under) begin
      r_err <= 1'b1;
    end
  end

  assign stack_err = r_err;
`endif

  assign data_o = r_data;
  assign pc     = r_pc;
  assign stop   = (w_cmd == `SEQ_STOP) || (w_cmd == 3'd7);

endmodule

`default_nettype wire

// File: tb/tb_sequencer_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequencer_core
// Brief    : Scoreboard bench for sequencer_core: a driver queues hand-computed
//            per-cycle expectations, a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================

module tb_sequencer_core;

  localparam int OCW  = 12;
  localparam int DDW  = 4;
  localparam int PLEN = 31;
  localparam int AW   = 5;

  localparam logic [2:0] OP_OUT = 3'd1, OP_CALL = 3'd3, OP_RET = 3'd4;
  localparam logic [2:0] OP_PUSHI = 3'd5, OP_DECJNZ = 3'd6, OP_STOP = 3'd0;

  function automatic logic [PLEN*OCW-1:0] mk_prog(input bit alt);
    logic [PLEN*OCW-1:0] p;
    p = '0;
    if (!alt) begin
      p[(PLEN-1-2)*OCW  +: OCW] = {OP_OUT,    5'd2,  4'b1001};
      p[(PLEN-1-3)*OCW  +: OCW] = {OP_OUT,    5'd2,  4'b1100};
      p[(PLEN-1-4)*OCW  +: OCW] = {OP_RET,    5'd2,  4'b0110};
      p[(PLEN-1-5)*OCW  +: OCW] = {OP_OUT,    5'd2,  4'b0011};
      p[(PLEN-1-6)*OCW  +: OCW] = {OP_OUT,    5'd2,  4'b1001};
      p[(PLEN-1-19)*OCW +: OCW] = {OP_PUSHI,  5'd5,  4'b0000};
      p[(PLEN-1-20)*OCW +: OCW] = {OP_CALL,   5'd3,  4'b1001};
      p[(PLEN-1-21)*OCW +: OCW] = {OP_DECJNZ, 5'd20, 4'b0011};
      p[(PLEN-1-22)*OCW +: OCW] = {OP_OUT,    5'd2,  4'b1001};
    end else begin
      p[(PLEN-1-1)*OCW  +: OCW] = {OP_PUSHI,  5'd7,  4'b0001};
      p[(PLEN-1-2)*OCW  +: OCW] = {OP_PUSHI,  5'd2,  4'b0010};
      p[(PLEN-1-3)*OCW  +: OCW] = {OP_PUSHI,  5'd9,  4'b0011};
      p[(PLEN-1-4)*OCW  +: OCW] = {OP_DECJNZ, 5'd6,  4'b0100};
      p[(PLEN-1-6)*OCW  +: OCW] = {OP_DECJNZ, 5'd6,  4'b0110};
      p[(PLEN-1-7)*OCW  +: OCW] = {OP_RET,    5'd1,  4'b0111};
      p[(PLEN-1-8)*OCW  +: OCW] = {OP_STOP,   5'd0,  4'b1000};
    end
    return p;
  endfunction

  localparam logic [PLEN*OCW-1:0] PROG_A = mk_prog(1'b0);
  localparam logic [PLEN*OCW-1:0] PROG_B = mk_prog(1'b1);

  logic          clk = 1'b0;
  logic          rst_a, jump_a, rst_b, jump_b;
  logic [AW-1:0] addr_a, addr_b, pc_a, pc_b;
  logic [3:0]    data_a, data_b;
  logic          stop_a, stop_b;
`ifdef SEQ_STACK_ERR_EN
  logic          err_a, err_b;
`endif

  always #5 clk = ~clk;

  sequencer_core #(.OCW(OCW), .DDW(DDW), .PLEN(PLEN), .STD(256), .PROGRAM(PROG_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .addr(addr_a), .jump(jump_a),
    .data_o(data_a), .pc(pc_a), .stop(stop_a)
`ifdef SEQ_STACK_ERR_EN
    , .stack_err(err_a)
`endif
  );

  sequencer_core #(.OCW(OCW), .DDW(DDW), .PLEN(PLEN), .STD(2), .PROGRAM(PROG_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .addr(addr_b), .jump(jump_b),
    .data_o(data_b), .pc(pc_b), .stop(stop_b)
`ifdef SEQ_STACK_ERR_EN
    , .stack_err(err_b)
`endif
  );

  typedef struct {
    bit         unit;
    logic [3:0] d;
    logic [4:0] p;
    logic       s;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_sample = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s sample=%0d: got %0h expected %0h", name, n_sample, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_sample++;
        if (!e.unit) begin
          chk("a.data_o", 32'(data_a), 32'(e.d));
          chk("a.pc",     32'(pc_a),   32'(e.p));
          chk("a.stop",   32'(stop_a), 32'(e.s));
        end else begin
          chk("b.data_o", 32'(data_b), 32'(e.d));
          chk("b.pc",     32'(pc_b),   32'(e.p));
          chk("b.stop",   32'(stop_b), 32'(e.s));
`ifdef SEQ_STACK_ERR_EN
          chk("b.stack_err", 32'(err_b), 32'(e.e));
`endif
        end
      end
    end
  end

  task automatic step_a(input logic r, input logic j, input logic [4:0] ad,
                        input logic [3:0] d, input logic [4:0] p, input logic s);
    rst_a = r; jump_a = j; addr_a = ad;
    @(posedge clk); #1;
    q.push_back('{unit: 1'b0, d: d, p: p, s: s, e: 1'b0});
  endtask

  task automatic step_b(input logic r, input logic j, input logic [4:0] ad,
                        input logic [3:0] d, input logic [4:0] p, input logic s,
                        input logic e);
    rst_b = r; jump_b = j; addr_b = ad;
    @(posedge clk); #1;
    q.push_back('{unit: 1'b1, d: d, p: p, s: s, e: e});
  endtask

  initial begin : driver
    rst_b = 1'b1; jump_b = 1'b0; addr_b = '0;

    // Reset, then idle at the STOP at address 0
    step_a(1, 0, 0, 4'h0, 5'd0, 1);
    step_a(1, 0, 0, 4'h0, 5'd0, 1);
    for (int k = 0; k < 3; k++) step_a(0, 0, 0, 4'h0, 5'd0, 1);

    // Single-cycle jump to 2: OUT/OUT/RET(empty)/OUT/OUT then STOP at 7
    step_a(0, 1, 2, 4'h0, 5'd2, 0);
    step_a(0, 0, 0, 4'h9, 5'd2, 0);
    step_a(0, 0, 0, 4'h9, 5'd3, 0);
    step_a(0, 0, 0, 4'hC, 5'd3, 0);
    step_a(0, 0, 0, 4'hC, 5'd4, 0);
    step_a(0, 0, 0, 4'h6, 5'd4, 0);
    step_a(0, 0, 0, 4'h6, 5'd5, 0);
    step_a(0, 0, 0, 4'h3, 5'd5, 0);
    step_a(0, 0, 0, 4'h3, 5'd6, 0);
    step_a(0, 0, 0, 4'h9, 5'd6, 0);
    step_a(0, 0, 0, 4'h9, 5'd7, 1);
    step_a(0, 0, 0, 4'h0, 5'd7, 1);
    step_a(0, 0, 0, 4'h0, 5'd7, 1);

    // Jump to 5, run two cycles, then hold jump to 3 for three cycles
    step_a(0, 1, 5, 4'h0, 5'd5, 0);
    step_a(0, 0, 0, 4'h3, 5'd5, 0);
    step_a(0, 0, 0, 4'h3, 5'd6, 0);
    for (int k = 0; k < 3; k++) step_a(0, 1, 3, 4'h3, 5'd3, 0);
    step_a(0, 0, 0, 4'hC, 5'd3, 0);
    step_a(0, 0, 0, 4'hC, 5'd4, 0);
    step_a(0, 0, 0, 4'h6, 5'd4, 0);
    step_a(0, 0, 0, 4'h6, 5'd5, 0);

    // Counted loop: PUSHI 5, five passes of CALL 3 / DECJNZ 20
    step_a(0, 1, 19, 4'h6, 5'd19, 0);
    step_a(0, 0, 0,  4'h0, 5'd20, 0);
    for (int k = 0; k < 5; k++) begin
      step_a(0, 0, 0, 4'h9, 5'd3, 0);
      step_a(0, 0, 0, 4'hC, 5'd3, 0);
      step_a(0, 0, 0, 4'hC, 5'd4, 0);
      step_a(0, 0, 0, 4'h6, 5'd4, 0);
      step_a(0, 0, 0, 4'h6, 5'd21, 0);
      step_a(0, 0, 0, 4'h3, (k < 4) ? 5'd20 : 5'd22, 0);
    end
    step_a(0, 0, 0, 4'h9, 5'd22, 0);
    step_a(0, 0, 0, 4'h9, 5'd23, 1);
    step_a(0, 0, 0, 4'h0, 5'd23, 1);

    // Jump mid-loop into the RET: stack was cleared so RET falls through
    step_a(0, 1, 19, 4'h0, 5'd19, 0);
    step_a(0, 0, 0,  4'h0, 5'd20, 0);
    step_a(0, 0, 0,  4'h9, 5'd3, 0);
    step_a(0, 0, 0,  4'hC, 5'd3, 0);
    step_a(0, 1, 4,  4'hC, 5'd4, 0);
    step_a(0, 0, 0,  4'h6, 5'd4, 0);
    step_a(0, 0, 0,  4'h6, 5'd5, 0);
    step_a(0, 0, 0,  4'h3, 5'd5, 0);

    // Reset wins over a simultaneous jump
    step_a(1, 1, 19, 4'h0, 5'd0, 1);
    step_a(0, 0, 0,  4'h0, 5'd0, 1);

    // Depth-2 stack: third PUSHI dropped, later ops see the original two entries
    step_b(1, 0, 0, 4'h0, 5'd0, 1, 0);
    step_b(1, 0, 0, 4'h0, 5'd0, 1, 0);
    step_b(0, 1, 1, 4'h0, 5'd1, 0, 0);
    step_b(0, 0, 0, 4'h1, 5'd2, 0, 0);
    step_b(0, 0, 0, 4'h2, 5'd3, 0, 0);
    step_b(0, 0, 0, 4'h3, 5'd4, 0, 1);
    step_b(0, 0, 0, 4'h4, 5'd6, 0, 1);
    step_b(0, 0, 0, 4'h6, 5'd7, 0, 1);
    step_b(0, 0, 0, 4'h7, 5'd7, 0, 1);
    step_b(0, 0, 0, 4'h7, 5'd8, 1, 1);
    step_b(0, 0, 0, 4'h8, 5'd8, 1, 1);
    step_b(0, 1, 8, 4'h8, 5'd8, 1, 0);
    step_b(0, 0, 0, 4'h8, 5'd8, 1, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sequencer_core.md
Name: sequencer_core

Overview:
- Small microcoded output sequencer. Each clock it executes one word of a parameter-constant program ROM and drives a data word on `data_o` for a programmed number of cycles.
- Supports jumps, subroutine call/return and counted loops through an internal LIFO stack.
- An external `jump` strobe loads the program counter from `addr` to start a sequence.
- Used as a pattern/waveform generator, e.g. stepper-motor phase sequences.

Parameters:
- ocw, 12: instruction word width = 3 (cmd) + aw (arg n) + ddw (data d); aw = ocw-3-ddw is the address/arg width.
- ddw, 4: data field and `data_o` width.
- plen, 31: number of program words; entries 0..plen-1.
- std, 256: stack depth in entries, each aw bits wide.
- program, all zero: plen*ocw bit vector. Entry 0 occupies the most-significant ocw bits. Each word is {cmd[2:0], n[aw-1:0], d[ddw-1:0]}.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr  in  aw  jump target.
- jump  in  1  load pc from addr.
- data_o  out  ddw  registered output data.
- pc  out  aw  current program counter, registered.
- stop  out  1  high while program[pc] is STOP, or pc >= plen; combinational from pc.

Behaviour:
- Opcodes, macros defined in the block's header: `SEQ_STOP`=0, `SEQ_OUT`=1, `SEQ_JMP`=2, `SEQ_CALL`=3, `SEQ_RET`=4, `SEQ_PUSHI`=5, `SEQ_DECJNZ`=6. Code 7 is reserved and executes as STOP.
- Reset: pc=0, cycle counter cnt=0, stack empty (sp=0), data_o=0. `rst` has priority over `jump`.
- `jump`=1 at an edge: pc<=addr, cnt<=0, stack emptied, data_o held. No instruction executes on that edge. Holding `jump` high keeps pc at addr.
- Otherwise each edge executes I=program[pc] and sets data_o<=I.d for every cmd. Let N = n, or 1 if n==0.
- STOP: pc and cnt hold. Also applies when pc >= plen.
- OUT: if cnt==N-1, then cnt<=0 and pc<=pc+1; else cnt<=cnt+1. Result: d is output for N consecutive cycles.
- RET: timing identical to OUT. On the final cycle, if the stack is non-empty, pc<=pop; if empty, pc<=pc+1.
- JMP: pc<=n, 1 cycle.
- CALL: push pc+1, pc<=n, 1 cycle.
- PUSHI: push n, pc<=pc+1, 1 cycle.
- DECJNZ: 1 cycle.
  - If the stack is empty or top<=1: pop (if non-empty), pc<=pc+1.
  - Else top<=top-1 and pc<=n.
  - Consequence: PUSHI k + DECJNZ executes the loop body k times (k=0 behaves as 1).
- pc+1 wraps from plen-1 to 0. All pc/stack arithmetic is aw bits.
- A push when sp==std is dropped. Control flow otherwise proceeds normally.
- data_o changes only on edges that execute an instruction, one-cycle latency from pc.

Optional Feature:
- Macro SEQ_STACK_ERR_EN.
- When defined: extra output `stack_err` (1 bit, registered). It is set sticky on a dropped push (overflow), or on a RET/DECJNZ that needs a pop with an empty stack. Cleared by rst or jump.
- When undefined: no port, no logic; overflow and underflow behave as in Behaviour.

Test Plan:

All scenarios use ocw=12, ddw=4 and this program:
- 0–1: STOP
- 2: OUT 2,1001
- 3: OUT 2,1100
- 4: RET 2,0110
- 5: OUT 2,0011
- 6: OUT 2,1001
- 7: STOP
- 19: PUSHI 5
- 20: CALL 3,1001
- 21: DECJNZ 20,0011
- 22: OUT 2,1001
- 23: STOP
- All other entries: STOP

Scenarios:
- Reset, no jump -> pc=0, stop=1, data_o=0 indefinitely.
- jump with addr=2 (1 cycle, then released) -> data_o sequence 1001×2, 1100×2, 0110×2 (RET on empty stack falls through), 0011×2, 1001×2. Then pc=7, stop=1, data_o=0.
- jump held for 3 cycles -> pc stays at addr, data_o unchanged, no execution until released.
- jump with addr=19 -> five iterations of: 0000 (PUSHI, first pass only), 1001, 1100×2, 0110×2, 0011. Then 1001×2 at 22 and stop at 23. No stack residue (sp=0).
- Push std+1 times (std=2 build) -> third push dropped; with SEQ_STACK_ERR_EN, stack_err=1 until the next jump.
- jump asserted mid-loop -> stack emptied, pc=addr next cycle; a RET executed afterwards falls through.
